// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: operation codes, FSM states and alu opcodes shared by the multiply/divide sequencer.
package mdu_seq_pkg;

    localparam logic [1:0] MDU_MUL  = 2'd0;
    localparam logic [1:0] MDU_DIVU = 2'd1;
    localparam logic [1:0] MDU_REMU = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == MDU_DIVU) || (op == MDU_REMU);
    endfunction

endpackage

// File: rtl/mdu_seq_alu.sv
// alu: purely combinational integer alu; the sequencer only uses ADD and SUB.
module alu
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_e         alu_op_i,
    output logic [XLEN-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (alu_op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle MUL/DIVU/REMU sequencer driving one shared alu.
// MUL is shift-add (optionally stopping when the multiplier runs out of ones); DIVU/REMU are restoring divide.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    mdu_state_e      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    alu_op_e         alu_op;
    logic [XLEN-1:0] rem_sh, rem_nx, quo_nx;
    logic            carry, ge, last_iter;

    alu #(.XLEN(XLEN)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .alu_op_i (alu_op),
        .y_o      (alu_y)
    );

    // In DIV, a_q holds the quotient shifting in from the dividend and acc_q the partial remainder.
    assign carry  = acc_q[XLEN-1];
    assign rem_sh = {acc_q[XLEN-2:0], a_q[XLEN-1]};
    assign ge     = carry | (rem_sh >= b_q);
    assign rem_nx = ge ? alu_y : rem_sh;
    assign quo_nx = {a_q[XLEN-2:0], ge};

    assign req_ready  = (state_q == ST_IDLE) && !flush;
    assign resp_valid = (state_q == ST_DONE);
    assign resp_data  = res_q;
    assign busy       = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_ADD;
        last_iter = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = is_div_op(req_op) ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                alu_a     = acc_q;
                alu_b     = a_q;
                acc_d     = b_q[0] ? alu_y : acc_q;
                a_d       = a_q << 1;
                b_d       = b_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                last_iter = (EARLY_EXIT && (b_q[XLEN-1:1] == '0)) || (cnt_q == LAST);
                if (last_iter) begin
                    res_d   = acc_d;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                alu_a  = rem_sh;
                alu_b  = b_q;
                alu_op = ALU_SUB;
                if (b_q == '0) begin
                    res_d   = (op_q == MDU_REMU) ? a_q : '1;
                    state_d = ST_DONE;
                end else begin
                    acc_d = rem_nx;
                    a_d   = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        res_d   = (op_q == MDU_REMU) ? rem_nx : quo_nx;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = resp_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

endmodule
